// File: rtl/synth_voice_scheduler_pkg.sv
// Shared constants, types and helpers for the PS/2 note-key voice scheduler.
package synth_voice_scheduler_pkg;

    localparam int unsigned KEY_W    = 2;
    localparam int unsigned NUM_KEYS = 4;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef logic [KEY_W-1:0] key_idx_t;

    localparam key_idx_t KEY_A = 2'd0;
    localparam key_idx_t KEY_S = 2'd1;
    localparam key_idx_t KEY_D = 2'd2;
    localparam key_idx_t KEY_F = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic     valid;
        key_idx_t key;
    } note_code_t;

    // Index width for a pool of n entries, never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

    function automatic note_code_t decode_note(input logic [7:0] code);
        note_code_t r;
        r = '{valid: 1'b1, key: KEY_A};
        case (code)
            SC_A:    r.key = KEY_A;
            SC_S:    r.key = KEY_S;
            SC_D:    r.key = KEY_D;
            SC_F:    r.key = KEY_F;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/synth_voice_scheduler_if.sv
// Scan-byte bus from the PS/2 receiver into the voice scheduler.
interface synth_voice_scheduler_if;
    logic [7:0] scan_byte;
    logic       scan_valid;

    modport master (output scan_byte, output scan_valid);
    modport slave  (input  scan_byte, input  scan_valid);
endinterface

// File: rtl/synth_voice_scheduler_decoder.sv
// PS/2 prefix FSM: turns F0/E0-prefixed scan bytes into make/break pulses for note keys.
module ps2_note_decoder
    import synth_voice_scheduler_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] scan_byte,
    input  logic       scan_valid,
    output logic       make_pulse_c,
    output logic       break_pulse_c,
    output key_idx_t   key_idx_c
);

    dec_state_t state_q;
    dec_state_t state_n;
    note_code_t note_c;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_n;
    end

    // Extended (E0) sequences are consumed without ever producing a pulse.
    always_comb begin
        state_n       = state_q;
        make_pulse_c  = 1'b0;
        break_pulse_c = 1'b0;
        note_c        = decode_note(scan_byte);
        key_idx_c     = note_c.key;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_byte == SC_BREAK)    state_n = ST_BRK;
                    else if (scan_byte == SC_EXT) state_n = ST_EXT;
                    else                          make_pulse_c = note_c.valid;
                end
                ST_BRK: begin
                    break_pulse_c = note_c.valid;
                    state_n       = ST_IDLE;
                end
                ST_EXT: begin
                    state_n = (scan_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/synth_voice_scheduler.sv
// Polyphonic voice allocator: tracks held note keys and assigns them to a fixed voice pool,
// stealing round-robin when every voice is sounding.
module synth_voice_scheduler
    import synth_voice_scheduler_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 2
)
(
    input  logic                      clock,
    input  logic                      resetn,
    synth_voice_scheduler_if.slave    scan,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [2*NUM_VOICES-1:0]   voice_key,
    output logic [NUM_KEYS-1:0]       keys_held,
    output logic                      note_event
);

    localparam int unsigned VW = clog2(NUM_VOICES);

    logic                    make_c;
    logic                    brk_c;
    key_idx_t                key_c;

    logic [VW-1:0]           steal_ptr;
    logic [VW-1:0]           steal_ptr_n;
    logic [NUM_VOICES-1:0]   gate_n;
    logic [2*NUM_VOICES-1:0] key_n;
    logic [NUM_KEYS-1:0]     held_n;
    logic                    event_n;
    logic                    free_found;
    logic [VW-1:0]           free_idx;
    logic [VW-1:0]           alloc_idx;

    ps2_note_decoder u_decoder (
        .clock         (clock),
        .resetn        (resetn),
        .scan_byte     (scan.scan_byte),
        .scan_valid    (scan.scan_valid),
        .make_pulse_c  (make_c),
        .break_pulse_c (brk_c),
        .key_idx_c     (key_c)
    );

    // Lowest-index silent voice.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!voice_gate[v] && !free_found) begin
                free_found = 1'b1;
                free_idx   = VW'(v);
            end
        end
    end

    // A repeat make of a held key is a no-op; a stolen key stays held but voiceless.
    always_comb begin
        gate_n      = voice_gate;
        key_n       = voice_key;
        held_n      = keys_held;
        steal_ptr_n = steal_ptr;
        alloc_idx   = free_found ? free_idx : steal_ptr;
        if (make_c && !keys_held[key_c]) begin
            held_n[key_c] = 1'b1;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (VW'(v) == alloc_idx) begin
                    gate_n[v]          = 1'b1;
                    key_n[2*v +: 2]    = key_c;
                end
            end
            if (!free_found)
                steal_ptr_n = (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + VW'(1);
        end else if (brk_c) begin
            held_n[key_c] = 1'b0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (voice_gate[v] && (voice_key[2*v +: 2] == key_c))
                    gate_n[v] = 1'b0;
            end
        end
        event_n = (gate_n != voice_gate) || (key_n != voice_key);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            voice_gate <= '0;
            voice_key  <= '0;
            keys_held  <= '0;
            steal_ptr  <= '0;
            note_event <= 1'b0;
        end else begin
            voice_gate <= gate_n;
            voice_key  <= key_n;
            keys_held  <= held_n;
            steal_ptr  <= steal_ptr_n;
            note_event <= event_n;
        end
    end

endmodule

// File: tb/tb_synth_voice_scheduler.sv
// Directed bench for the voice scheduler with two voices.
module tb_synth_voice_scheduler;

    logic       clock;
    logic       resetn;
    logic [1:0] voice_gate;
    logic [3:0] voice_key;
    logic [3:0] keys_held;
    logic       note_event;
    int         tests;
    int         fails;
    int         ev_count;

    synth_voice_scheduler_if scan_if ();

    synth_voice_scheduler #(.NUM_VOICES(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .scan       (scan_if),
        .voice_gate (voice_gate),
        .voice_key  (voice_key),
        .keys_held  (keys_held),
        .note_event (note_event)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs updated.
    task automatic send(input logic [7:0] b);
        scan_if.scan_byte  = b;
        scan_if.scan_valid = 1'b1;
        @(negedge clock);
        scan_if.scan_valid = 1'b0;
        scan_if.scan_byte  = 8'h00;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetn = 1'b0;
        scan_if.scan_byte  = 8'h00;
        scan_if.scan_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_gate", 32'(voice_gate), 32'h0);
        check("rst_key",  32'(voice_key),  32'h0);
        check("rst_held", 32'(keys_held),  32'h0);
        check("rst_event", 32'(note_event), 32'h0);
        resetn = 1'b1;
        @(negedge clock);

        // Reset in the middle of a break prefix
        send(8'h1C);
        check("mb_make_gate", 32'(voice_gate), 32'h1);
        send(8'hF0);
        #2 resetn = 1'b0;
        #1;
        check("mb_async_gate", 32'(voice_gate), 32'h0);
        check("mb_async_held", 32'(keys_held), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        send(8'h1C);
        check("mb_after_gate", 32'(voice_gate), 32'h1);
        check("mb_after_key",  32'(voice_key),  32'h0);
        check("mb_after_held", 32'(keys_held),  32'h1);
        check("mb_after_event", 32'(note_event), 32'h1);

        // Basic hold and release
        do_reset();
        send(8'h1C);
        check("bh_a_gate", 32'(voice_gate), 32'h1);
        check("bh_a_event", 32'(note_event), 32'h1);
        send(8'h23);
        check("bh_d_gate", 32'(voice_gate), 32'h3);
        check("bh_d_key",  32'(voice_key),  32'h8);
        check("bh_d_held", 32'(keys_held),  32'h5);
        send(8'hF0);
        check("bh_f0_event", 32'(note_event), 32'h0);
        send(8'h1C);
        check("bh_rel_gate", 32'(voice_gate), 32'h2);
        check("bh_rel_key",  32'(voice_key),  32'h8);
        check("bh_rel_held", 32'(keys_held),  32'h4);
        check("bh_rel_event", 32'(note_event), 32'h1);
        @(negedge clock);
        check("bh_event_pulse", 32'(note_event), 32'h0);

        // Typematic repeat
        do_reset();
        ev_count = 0;
        send(8'h1B); ev_count += int'(note_event);
        send(8'h1B); ev_count += int'(note_event);
        send(8'h1B); ev_count += int'(note_event);
        check("ty_events", 32'(ev_count), 32'd1);
        check("ty_key",  32'(voice_key),  32'h1);
        check("ty_gate", 32'(voice_gate), 32'h1);
        send(8'hF0);
        send(8'h1B);
        check("ty_rel_gate", 32'(voice_gate), 32'h0);
        check("ty_rel_held", 32'(keys_held),  32'h0);
        check("ty_rel_key",  32'(voice_key),  32'h1);
        check("ty_rel_event", 32'(note_event), 32'h1);

        // Voice stealing
        do_reset();
        send(8'h1C);
        send(8'h1B);
        check("st_full_key", 32'(voice_key), 32'h4);
        send(8'h23);
        check("st_d_key",   32'(voice_key),  32'h6);
        check("st_d_gate",  32'(voice_gate), 32'h3);
        check("st_d_held",  32'(keys_held),  32'h7);
        check("st_d_event", 32'(note_event), 32'h1);
        check("st_d_ptr",   32'(dut.steal_ptr), 32'h1);
        send(8'h2B);
        check("st_f_key",  32'(voice_key), 32'hE);
        check("st_f_held", 32'(keys_held), 32'hF);
        check("st_f_ptr",  32'(dut.steal_ptr), 32'h0);
        send(8'hF0);
        send(8'h1C);
        check("st_rel_held",  32'(keys_held),  32'hE);
        check("st_rel_event", 32'(note_event), 32'h0);
        check("st_rel_gate",  32'(voice_gate), 32'h3);
        check("st_rel_key",   32'(voice_key),  32'hE);

        // Prefix filtering
        do_reset();
        send(8'hE0);
        send(8'h1C);
        check("pf_ext_held",  32'(keys_held),  32'h0);
        check("pf_ext_gate",  32'(voice_gate), 32'h0);
        check("pf_ext_event", 32'(note_event), 32'h0);
        send(8'h1C);
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        check("pf_extbrk_held",  32'(keys_held),  32'h1);
        check("pf_extbrk_gate",  32'(voice_gate), 32'h1);
        check("pf_extbrk_event", 32'(note_event), 32'h0);
        send(8'h5A);
        check("pf_other_held",  32'(keys_held),  32'h1);
        check("pf_other_event", 32'(note_event), 32'h0);
        do_reset();
        send(8'hF0);
        send(8'h5A);
        send(8'h1C);
        check("pf_brkother_gate",  32'(voice_gate), 32'h1);
        check("pf_brkother_held",  32'(keys_held),  32'h1);
        check("pf_brkother_event", 32'(note_event), 32'h1);

        // Free-slot priority
        do_reset();
        send(8'h1C);
        send(8'h1B);
        send(8'hF0);
        send(8'h1C);
        check("fp_rel_gate", 32'(voice_gate), 32'h2);
        send(8'h23);
        check("fp_d_gate", 32'(voice_gate), 32'h3);
        check("fp_d_key",  32'(voice_key),  32'h6);
        check("fp_d_held", 32'(keys_held),  32'h6);
        check("fp_d_ptr",  32'(dut.steal_ptr), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
